// File: rtl/jmp_seq_unit.sv
// jmp_seq_unit: sequential branch-resolution unit.
// Decodes a jump instruction, samples the ALU flags at start, collects
// ADDR_W/DATA_W operand bytes (MSB first) and drives the new PC for one cycle.
// Optional hardware call/return stack: define JMP_CALL_STACK_EN.
module jmp_seq_unit #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        cins,
  input  logic              start,
  input  logic [DATA_W-1:0] databus,
  input  logic              byte_valid,
  input  logic [ADDR_W-1:0] pcin,
  input  logic              zflag,
  input  logic              oflag,
  input  logic              cflag,
  input  logic              sflag,
  output logic              busy,
  output logic              done,
  output logic              pcoe,
  output logic [ADDR_W-1:0] pcout,
  output logic              stack_err
);

  localparam int unsigned NB    = ADDR_W / DATA_W;
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NB - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESOLVE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_JMP  = 2'b00,
    OP_CALL = 2'b01,
    OP_RET  = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [3:0]        cond_q, cond_d;
  logic              rel_q, rel_d;
  logic              zf_q, zf_d;
  logic              of_q, of_d;
  logic              cf_q, cf_d;
  logic              sf_q, sf_d;
  logic [ADDR_W-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              cond_met;
  logic [ADDR_W-1:0] target;

  // cins[7] carries no meaning; parameter only matters with the stack build
  logic unused_sink;
  assign unused_sink = ^{1'b0, cins[7], (STACK_DEPTH > 1)};

`ifdef JMP_CALL_STACK_EN
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned IDX_W = SP_W - 1;

  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0] stack_mem_q [STACK_DEPTH];
  logic              push, pop;
  logic              stk_full, stk_empty;
  logic [IDX_W-1:0]  top_idx;

  assign stk_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp_q == '0);
  assign top_idx   = IDX_W'(sp_q - 1'b1);

  // Stack pointer: counts live entries, emptied by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // Stack storage: the pushed return address is the latched base
  always_ff @(posedge clk) begin
    if (push) stack_mem_q[sp_q[IDX_W-1:0]] <= base_q;
  end

  // Stack pointer next value
  always_comb begin
    sp_d = sp_q;
    if (push)     sp_d = sp_q + 1'b1;
    else if (pop) sp_d = sp_q - 1'b1;
  end
`endif

  // State and operand registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_JMP;
      cond_q  <= '0;
      rel_q   <= 1'b0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      cf_q    <= 1'b0;
      sf_q    <= 1'b0;
      shift_q <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cond_q  <= cond_d;
      rel_q   <= rel_d;
      zf_q    <= zf_d;
      of_q    <= of_d;
      cf_q    <= cf_d;
      sf_q    <= sf_d;
      shift_q <= shift_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: instruction latch, byte collection, single resolve cycle
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cond_d  = cond_q;
    rel_d   = rel_q;
    zf_d    = zf_q;
    of_d    = of_q;
    cf_d    = cf_q;
    sf_d    = sf_q;
    shift_d = shift_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_e'(cins[6:5]);
          cond_d  = cins[3:0];
          rel_d   = cins[4];
          zf_d    = zflag;
          of_d    = oflag;
          cf_d    = cflag;
          sf_d    = sflag;
          shift_d = '0;
          cnt_d   = '0;
          state_d = (op_e'(cins[6:5]) == OP_RET) ? RESOLVE : COLLECT;
        end
      end
      COLLECT: begin
        if (byte_valid) begin
          shift_d = (shift_q << DATA_W) | ADDR_W'(databus);
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            base_d  = pcin;
            state_d = RESOLVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Condition evaluation against the flags sampled at start
  always_comb begin
    cond_met = 1'b0;
    unique case (cond_q)
      4'd0:    cond_met = 1'b1;
      4'd1:    cond_met = zf_q;
      4'd2:    cond_met = !zf_q;
      4'd3:    cond_met = cf_q;
      4'd4:    cond_met = cf_q | zf_q;
      4'd5:    cond_met = !(cf_q | zf_q);
      4'd6:    cond_met = !cf_q;
      4'd7:    cond_met = of_q ^ sf_q;
      4'd8:    cond_met = (of_q ^ sf_q) | zf_q;
      4'd9:    cond_met = !(of_q ^ sf_q) & !zf_q;
      4'd10:   cond_met = !(of_q ^ sf_q);
      default: cond_met = 1'b0;
    endcase
  end

  // Outputs: completion pulse, PC load and optional stack push/pop
  always_comb begin
    busy      = (state_q != IDLE);
    done      = 1'b0;
    pcoe      = 1'b0;
    pcout     = '0;
    stack_err = 1'b0;
    target    = rel_q ? (base_q + shift_q) : shift_q;
`ifdef JMP_CALL_STACK_EN
    push      = 1'b0;
    pop       = 1'b0;
`endif
    if (state_q == RESOLVE) begin
      done = 1'b1;
      unique case (op_q)
        OP_JMP: pcoe = cond_met;
`ifdef JMP_CALL_STACK_EN
        OP_CALL: begin
          if (cond_met) begin
            if (stk_full) stack_err = 1'b1;
            else begin
              pcoe = 1'b1;
              push = 1'b1;
            end
          end
        end
        OP_RET: begin
          if (cond_met) begin
            if (stk_empty) stack_err = 1'b1;
            else begin
              pcoe   = 1'b1;
              pop    = 1'b1;
              target = stack_mem_q[top_idx];
            end
          end
        end
`else
        OP_CALL: pcoe = cond_met;
        OP_RET:  pcoe = 1'b0;
`endif
        default: pcoe = 1'b0;
      endcase
      if (pcoe) pcout = target;
    end
  end

endmodule

// File: tb/tb_jmp_seq_unit.sv
// Self-checking bench for jmp_seq_unit (default parameters).
// Stack scenarios run only when JMP_CALL_STACK_EN is defined.
module tb_jmp_seq_unit;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned NB    = AW / DW;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    cins;
  logic          start;
  logic [DW-1:0] databus;
  logic          byte_valid;
  logic [AW-1:0] pcin;
  logic          zflag, oflag, cflag, sflag;
  logic          busy, done, pcoe, stack_err;
  logic [AW-1:0] pcout;

  int total = 0;
  int bad   = 0;

  // Reference return stack (only consulted in the stack build)
  logic [AW-1:0] ref_stk [$];

  jmp_seq_unit #(.ADDR_W(AW), .DATA_W(DW), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cins(cins), .start(start),
    .databus(databus), .byte_valid(byte_valid), .pcin(pcin),
    .zflag(zflag), .oflag(oflag), .cflag(cflag), .sflag(sflag),
    .busy(busy), .done(done), .pcoe(pcoe), .pcout(pcout),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ok(input int sel, input bit z, input bit o, input bit c, input bit s);
    bit lt;
    lt = (o != s);
    case (sel)
      0:  return 1'b1;
      1:  return z;
      2:  return !z;
      3:  return c;
      4:  return c || z;
      5:  return !c && !z;
      6:  return !c;
      7:  return lt;
      8:  return lt || z;
      9:  return !lt && !z;
      10: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  // One complete operation starting #1 after a rising edge; checks every cycle.
  task automatic run_op(input logic [7:0] c, input bit z, input bit o, input bit cf, input bit s,
                        input logic [AW-1:0] opnd, input logic [AW-1:0] pc,
                        input int gap, input bit flip);
    int op;
    bit cond, taken, err;
    logic [AW-1:0] tgt;
    op = int'(c[6:5]);
    cins = c; start = 1'b1;
    zflag = z; oflag = o; cflag = cf; sflag = s;
    @(posedge clk); #1;
    start = 1'b0;
    cins = 8'($urandom);
    if (flip) {zflag, oflag, cflag, sflag} = ~{z, o, cf, s};
    check("busy_after_start", busy, 1);
    if (op != 2) begin
      for (int i = 0; i < int'(NB); i++) begin
        for (int g = 0; g < gap; g++) begin
          byte_valid = 1'b0; start = 1'b1;
          databus = DW'($urandom); pcin = AW'($urandom);
          @(posedge clk); #1;
          check("busy_stall", busy, 1);
          check("done_stall", done, 0);
        end
        start = 1'b0; byte_valid = 1'b1;
        databus = DW'(opnd >> (DW * (NB - 1 - i)));
        pcin = (i == int'(NB) - 1) ? pc : AW'($urandom);
        @(posedge clk); #1;
        byte_valid = 1'b0;
        pcin = AW'($urandom);
        check("busy_collect", busy, 1);
      end
    end
    // Reference outcome
    cond = cond_ok(int'(c[3:0]), z, o, cf, s);
    taken = 1'b0; err = 1'b0; tgt = '0;
    case (op)
      0: taken = cond;
`ifdef JMP_CALL_STACK_EN
      1: if (cond) begin
           if (ref_stk.size() == DEPTH) err = 1'b1;
           else begin taken = 1'b1; ref_stk.push_back(pc); end
         end
      2: if (cond) begin
           if (ref_stk.size() == 0) err = 1'b1;
           else begin taken = 1'b1; tgt = ref_stk.pop_back(); end
         end
`else
      1: taken = cond;
      2: taken = 1'b0;
`endif
      default: taken = 1'b0;
    endcase
    if (taken && op != 2) tgt = c[4] ? AW'(pc + opnd) : opnd;
    if (!taken) tgt = '0;
    // Stray byte_valid during RESOLVE must be ignored
    byte_valid = 1'b1; databus = DW'($urandom);
    check("done_resolve", done, 1);
    check("busy_resolve", busy, 1);
    check("pcoe_resolve", pcoe, taken);
    check("pcout_resolve", pcout, tgt);
    check("stack_err_resolve", stack_err, err);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    check("done_after", done, 0);
    check("pcoe_after", pcoe, 0);
    check("pcout_after", pcout, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    reset = 1'b0; cins = '0; start = 1'b0; databus = '0; byte_valid = 1'b0;
    pcin = '0; zflag = 1'b0; oflag = 1'b0; cflag = 1'b0; sflag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pcoe", pcoe, 0);
    check("rst_pcout", pcout, 0);
    check("rst_stack_err", stack_err, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Absolute JMP 0x1234
    run_op(8'h00, 0, 0, 0, 0, 16'h1234, 16'h4000, 0, 0);
    // Relative wrap-around
    run_op(8'h10, 0, 0, 0, 0, 16'h0020, 16'hFFF0, 0, 0);
    // Flags sampled only at start, bytes with 3-cycle gaps
    run_op(8'h01, 1, 0, 0, 0, 16'hBEEF, 16'h0100, 3, 1);
    run_op(8'h01, 0, 0, 0, 0, 16'hBEEF, 16'h0100, 3, 1);
    // Signed conditions with o=1, s=0, z=0; select 13 never taken
    run_op(8'h07, 0, 1, 0, 0, 16'h2222, 16'h0000, 0, 0);
    run_op(8'h08, 0, 1, 0, 0, 16'h3333, 16'h0000, 0, 0);
    run_op(8'h09, 0, 1, 0, 0, 16'h4444, 16'h0000, 0, 0);
    run_op(8'h0A, 0, 1, 0, 0, 16'h5555, 16'h0000, 0, 0);
    run_op(8'h0D, 1, 1, 1, 1, 16'h6666, 16'h0000, 0, 0);
    // Reserved op: never taken, bytes still consumed
    run_op(8'h60, 0, 0, 0, 0, 16'h7777, 16'h0000, 0, 0);

`ifdef JMP_CALL_STACK_EN
    for (int i = 0; i < 5; i++)
      run_op(8'h20, 0, 0, 0, 0, 16'h0100, AW'(16'h0A00 + i), 0, 0);
    for (int i = 0; i < 5; i++)
      run_op(8'h40, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
`else
    // CALL behaves as JMP, RET completes not taken
    run_op(8'h30, 0, 0, 0, 0, 16'h0010, 16'h0A00, 0, 0);
    run_op(8'h40, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
`endif

    // Reset in the middle of COLLECT after one byte
    cins = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; byte_valid = 1'b1; databus = 8'hAB;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    ref_stk.delete();
    @(posedge clk); #1;
    check("midrst_done_hold", done, 0);
    check("midrst_pcoe_hold", pcoe, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("postrst_busy", busy, 0);
    check("postrst_done", done, 0);
    run_op(8'h00, 0, 0, 0, 0, 16'h5678, 16'h1111, 0, 0);

    // Randomized operations against the reference model
    for (int n = 0; n < 60; n++) begin
      logic [7:0] rc;
      rc = {1'b0, 7'($urandom)};
      run_op(rc, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             AW'($urandom), AW'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
